// File: rtl/bram_rd_responder_pkg.sv
// Shared types and helpers for the BRAM read responder.
// Optional parity storage is enabled with the BRAM_PARITY_EN macro.
package bram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int RD_LAT = 2;

`ifdef BRAM_PARITY_EN
   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_par(input logic [63:0] data);
      return ^data;
   endfunction
`endif

endpackage

// File: rtl/bram_rd_responder_if.sv
// Request/response bus between the stimulus generator (master) and the
// BRAM responder (slave).
interface bram_rd_responder_if #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             rdy;
   logic             rd;
   logic [AW-1:0]    raddr;
   logic             wr;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic             rd_valid;
   logic [WIDTH-1:0] rdata;
   logic             req_drop;
   logic             rd_perr;

   modport master (
      input  rdy, rd_valid, rdata, req_drop, rd_perr,
      output rd, raddr, wr, waddr, wdata
   );

   modport slave (
      output rdy, rd_valid, rdata, req_drop, rd_perr,
      input  rd, raddr, wr, waddr, wdata
   );
endinterface

// File: rtl/bram_rd_responder_pipe.sv
// Two-stage read return pipeline (stage 1 word, stage 2 output register).
// With BRAM_PARITY_EN the stored parity is checked between the stages.
module bram_rd_pipe
   import bram_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_vld,
   input  logic [WIDTH-1:0] i_data,
`ifdef BRAM_PARITY_EN
   input  logic             i_par,
`endif
   output logic             o_vld,
   output logic [WIDTH-1:0] o_data,
   output logic             o_perr
);

   logic             r_s1_vld;
   logic [WIDTH-1:0] r_s1_data;
   logic             r_s2_vld;
   logic [WIDTH-1:0] r_s2_data;

   // Output data only moves on valid cycles so rdata holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_data <= '0;
         r_s2_vld  <= 1'b0;
         r_s2_data <= '0;
      end else begin
         r_s1_vld <= i_vld;
         if (i_vld) r_s1_data <= i_data;
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) r_s2_data <= r_s1_data;
      end
   end

`ifdef BRAM_PARITY_EN
   logic r_s1_par;
   logic r_s2_perr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_par  <= 1'b0;
         r_s2_perr <= 1'b0;
      end else begin
         if (i_vld) r_s1_par <= i_par;
         r_s2_perr <= r_s1_vld && (even_par(64'(r_s1_data)) != r_s1_par);
      end
   end

   assign o_perr = r_s2_perr;
`else
   assign o_perr = 1'b0;
`endif

   assign o_vld  = r_s2_vld;
   assign o_data = r_s2_data;

endmodule

// File: rtl/bram_rd_responder.sv
// BRAM model with zero-fill init sequencer and fixed-latency read return.
// BRAM_PARITY_EN adds a per-word even-parity bit and rd_perr reporting.
//
// state | meaning
// INIT  | zero-filling word r_ptr each cycle; requests dropped, rdy=0
// RUN   | rdy=1; reads and writes accepted until reset
module bram_rd_responder
   import bram_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   bram_rd_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_ptr;
   logic [AW-1:0]    w_ptr_nxt;
   logic             r_req_drop;
   logic             r_rd_vld;
   logic [WIDTH-1:0] r_rd_data;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_accept_rd;
   logic             w_accept_wr;

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         INIT: begin
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr == AW'(DEPTH - 1)) w_state_nxt = RUN;
         end
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = INIT;
      endcase
   end

   assign w_accept_rd = (r_state == RUN) && bus.rd;
   assign w_accept_wr = (r_state == RUN) && bus.wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= INIT;
         r_ptr      <= '0;
         r_req_drop <= 1'b0;
         r_rd_vld   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_req_drop <= (r_state == INIT) && (bus.rd || bus.wr);
         r_rd_vld   <= w_accept_rd;
      end
   end

   // Array read and write share the sampling edge, so a colliding read sees old data.
   always_ff @(posedge clk) begin
      if (r_state == INIT) r_mem[r_ptr] <= '0;
      else if (w_accept_wr) r_mem[bus.waddr] <= bus.wdata;
      if (w_accept_rd) r_rd_data <= r_mem[bus.raddr];
   end

`ifdef BRAM_PARITY_EN
   logic [DEPTH-1:0] r_par;
   logic             r_rd_par;

   always_ff @(posedge clk) begin
      if (r_state == INIT) r_par[r_ptr] <= 1'b0;
      else if (w_accept_wr) r_par[bus.waddr] <= even_par(64'(bus.wdata));
      if (w_accept_rd) r_rd_par <= r_par[bus.raddr];
   end
`endif

   bram_rd_pipe #(
      .WIDTH (WIDTH)
   ) u_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_vld  (r_rd_vld),
      .i_data (r_rd_data),
`ifdef BRAM_PARITY_EN
      .i_par  (r_rd_par),
`endif
      .o_vld  (bus.rd_valid),
      .o_data (bus.rdata),
      .o_perr (bus.rd_perr)
   );

   assign bus.rdy      = (r_state == RUN);
   assign bus.req_drop = r_req_drop;

endmodule

// File: tb/tb_bram_rd_responder.sv
// Directed bench for bram_rd_responder: init sequencing, read latency,
// streaming, read-first collision, init drops and mid-flight reset.
module tb_bram_rd_responder;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;
   localparam int LAT   = bram_pkg::RD_LAT;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   bram_rd_responder_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   bram_rd_responder #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish (got running, need finished)");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one request cycle, take the edge, then check the outputs it produced.
   task automatic step(input logic rd, input int ra, input logic wr, input int wa,
                       input int wd, input logic ev, input int ed, input logic ep = 1'b0);
      bus.rd    = rd;
      bus.raddr = ra[3:0];
      bus.wr    = wr;
      bus.waddr = wa[3:0];
      bus.wdata = wd[7:0];
      @(posedge clk);
      #1;
      chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, ev});
      chk("rdata", {24'd0, bus.rdata}, ed);
      chk("req_drop", {31'd0, bus.req_drop}, 32'd0);
      chk("rd_perr", {31'd0, bus.rd_perr}, {31'd0, ep});
   endtask

   // Release reset and walk the zero-fill; optional requests at given edges must be dropped.
   task automatic init_seq(input int rd_edge, input int wr_edge);
      rst_n = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         bus.rd    = (i == rd_edge);
         bus.raddr = 4'd0;
         bus.wr    = (i == wr_edge);
         bus.waddr = 4'd0;
         bus.wdata = 8'hEE;
         @(posedge clk);
         #1;
         chk("init_rdy", {31'd0, bus.rdy}, {31'd0, (i == DEPTH)});
         chk("init_drop", {31'd0, bus.req_drop}, {31'd0, (i == rd_edge) || (i == wr_edge)});
         chk("init_vld", {31'd0, bus.rd_valid}, 32'd0);
      end
      bus.rd = 1'b0;
      bus.wr = 1'b0;
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      bus.rd    = 1'b0;
      bus.raddr = '0;
      bus.wr    = 1'b0;
      bus.waddr = '0;
      bus.wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", {31'd0, bus.rdy}, 32'd0);
      chk("rst_vld", {31'd0, bus.rd_valid}, 32'd0);
      chk("rst_rdata", {24'd0, bus.rdata}, 32'd0);
      chk("rst_drop", {31'd0, bus.req_drop}, 32'd0);
      chk("rst_perr", {31'd0, bus.rd_perr}, 32'd0);

      // rd on edge 2 and wr on edge 16 (rdy-rise edge) are both dropped.
      init_seq(2, DEPTH);

      // Readback of every word: all zero, including addr 0 whose late write was dropped.
      for (int j = 0; j < DEPTH + LAT; j++)
         step(j < DEPTH, j, 1'b0, 0, 0, j >= LAT, 0);
      step(1'b0, 0, 1'b0, 0, 0, 1'b0, 0);

      // Basic latency: write 3, idle, read 3 at edge N.
      step(1'b0, 0, 1'b1, 3, 'hA5, 1'b0, 'h00);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'h00);
      step(1'b1, 3, 1'b0, 0, 0,    1'b0, 'h00);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'h00);
      step(1'b0, 0, 1'b0, 0, 0,    1'b1, 'hA5);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'hA5);

      // Streaming reads of preloaded words 1 and 2.
      step(1'b0, 0, 1'b1, 1, 'h11, 1'b0, 'hA5);
      step(1'b0, 0, 1'b1, 2, 'h22, 1'b0, 'hA5);
      step(1'b1, 1, 1'b0, 0, 0,    1'b0, 'hA5);
      step(1'b1, 2, 1'b0, 0, 0,    1'b0, 'hA5);
      step(1'b0, 0, 1'b0, 0, 0,    1'b1, 'h11);
      step(1'b0, 0, 1'b0, 0, 0,    1'b1, 'h22);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'h22);

      // Read-first collision on addr 5, then a later read sees the new word.
      step(1'b0, 0, 1'b1, 5, 'h0F, 1'b0, 'h22);
      step(1'b1, 5, 1'b1, 5, 'hF0, 1'b0, 'h22);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'h22);
      step(1'b1, 5, 1'b0, 0, 0,    1'b1, 'h0F);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'h0F);
      step(1'b0, 0, 1'b0, 0, 0,    1'b1, 'hF0);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'hF0);

      // Write at edge N is visible to a read at edge N+1.
      step(1'b0, 0, 1'b1, 9, 'h3C, 1'b0, 'hF0);
      step(1'b1, 9, 1'b0, 0, 0,    1'b0, 'hF0);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'hF0);
      step(1'b0, 0, 1'b0, 0, 0,    1'b1, 'h3C);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'h3C);

      // Mid-flight reset: read 3 is in the pipe when rst_n drops.
      step(1'b1, 3, 1'b0, 0, 0, 1'b0, 'h3C);
      step(1'b0, 0, 1'b0, 0, 0, 1'b0, 'h3C);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", {31'd0, bus.rd_valid}, 32'd0);
      chk("mid_rst_rdy", {31'd0, bus.rdy}, 32'd0);
      chk("mid_rst_rdata", {24'd0, bus.rdata}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("mid_rst_hold_vld", {31'd0, bus.rd_valid}, 32'd0);
      end
      init_seq(0, 0);

      // Zero-fill reran: words written before the reset read back as zero.
      step(1'b1, 3, 1'b0, 0, 0, 1'b0, 'h00);
      step(1'b1, 9, 1'b0, 0, 0, 1'b0, 'h00);
      step(1'b0, 0, 1'b0, 0, 0, 1'b1, 'h00);
      step(1'b0, 0, 1'b0, 0, 0, 1'b1, 'h00);
      step(1'b0, 0, 1'b0, 0, 0, 1'b0, 'h00);

`ifdef BRAM_PARITY_EN
      // 0x07 has odd weight so its stored parity is 1; forcing it to 0 must flag.
      step(1'b0, 0, 1'b1, 7, 'h07, 1'b0, 'h00);
      force dut.r_par[7] = 1'b0;
      step(1'b1, 7, 1'b0, 0, 0,    1'b0, 'h00);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'h00);
      step(1'b0, 0, 1'b0, 0, 0,    1'b1, 'h07, 1'b1);
      release dut.r_par[7];
      step(1'b0, 0, 1'b1, 7, 'h07, 1'b0, 'h07);
      step(1'b1, 7, 1'b0, 0, 0,    1'b0, 'h07);
      step(1'b0, 0, 1'b0, 0, 0,    1'b0, 'h07);
      step(1'b0, 0, 1'b0, 0, 0,    1'b1, 'h07, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
